// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU register-file sequencer: command kinds, FSM states, data width.
// Pure declarations, no timing or flow-control behaviour of its own.
package alu_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    COMPUTE = 2'd0,
    ACCUM   = 2'd1,
    SWAP    = 2'd2,
    READ    = 2'd3
  } cmd_kind_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_EXEC = 3'd3,
    S_SWP  = 3'd4,
    S_CAPT = 3'd5,
    S_RESP = 3'd6
  } seq_state_t;

endpackage

// File: rtl/alu_reg_sequencer.sv
// Sequences register-file strobes for one command, then returns captured A/B; result valid
// 5/4/3/2 edges after accept (COMPUTE/ACCUM/SWAP/READ); res_ready low holds the result, cmd_ready low.
module alu_reg_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_FUNC_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_kind,
  input  logic [DATA_W-1:0]     cmd_opa,
  input  logic [DATA_W-1:0]     cmd_opb,
  input  logic [ALU_FUNC_W-1:0] cmd_func,
  output logic [DATA_W-1:0]     data_in,
  output logic                  load_a,
  output logic                  load_b,
  output logic                  swap,
  output logic                  store,
  output logic [ALU_FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0]     reg_a,
  input  logic [DATA_W-1:0]     reg_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_a,
  output logic [DATA_W-1:0]     res_b
);

  seq_state_t            state;
  logic [DATA_W-1:0]     opa_q;
  logic [DATA_W-1:0]     opb_q;
  logic [ALU_FUNC_W-1:0] func_q;

  // The command kind is recorded by the path taken out of IDLE, so no kind register is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      opa_q  <= '0;
      opb_q  <= '0;
      func_q <= '0;
      res_a  <= '0;
      res_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            opa_q  <= cmd_opa;
            opb_q  <= cmd_opb;
            func_q <= cmd_func;
            case (cmd_kind)
              COMPUTE: state <= S_LDA;
              ACCUM:   state <= S_LDB;
              SWAP:    state <= S_SWP;
              default: state <= S_CAPT;
            endcase
          end
        end
        S_LDA:  state <= S_LDB;
        S_LDB:  state <= S_EXEC;
        S_EXEC: state <= S_CAPT;
        S_SWP:  state <= S_CAPT;
        S_CAPT: begin
          res_a <= reg_a;
          res_b <= reg_b;
          state <= S_RESP;
        end
        S_RESP: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    load_a    = 1'b0;
    load_b    = 1'b0;
    swap      = 1'b0;
    store     = 1'b0;
    data_in   = '0;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    alu_func  = func_q;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        alu_func  = '0;
      end
      S_LDA: begin
        load_a  = 1'b1;
        data_in = opa_q;
      end
      S_LDB: begin
        load_b  = 1'b1;
        data_in = opb_q;
      end
      S_EXEC: store     = 1'b1;
      S_SWP:  swap      = 1'b1;
      S_RESP: res_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Bench for alu_reg_sequencer with a behavioural register file and ALU around it.
module tb_alu_reg_sequencer;
  import alu_seq_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_kind;
  logic [7:0] cmd_opa, cmd_opb;
  logic [2:0] cmd_func, alu_func;
  logic [7:0] data_in;
  logic       load_a, load_b, swap, store;
  logic [7:0] reg_a, reg_b;
  logic       res_valid, res_ready;
  logic [7:0] res_a, res_b;
  logic [7:0] alu_y;
  logic       rf_rst;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  alu_reg_sequencer #(.ALU_FUNC_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_func(cmd_func),
    .data_in(data_in), .load_a(load_a), .load_b(load_b), .swap(swap), .store(store),
    .alu_func(alu_func), .reg_a(reg_a), .reg_b(reg_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a), .res_b(res_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with its own active-high reset; the ALU result is stored back into A.
  assign rf_rst = ~reset_n;
  always @(posedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      reg_a <= 8'h00;
      reg_b <= 8'h00;
    end else if (load_a) reg_a <= data_in;
    else if (load_b) reg_b <= data_in;
    else if (swap) begin
      reg_a <= reg_b;
      reg_b <= reg_a;
    end else if (store) reg_a <= alu_y;
  end

  function automatic logic [7:0] alu_fn(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_y = alu_fn(alu_func, reg_a, reg_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectation queue filled at accept time from the model.
  typedef struct packed {
    logic [3:0] strb;   // {load_a, load_b, swap, store}
    logic [7:0] din;
    logic [2:0] func;
    logic       rv;
    logic [7:0] ra;
    logic [7:0] rb;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  time t_acc = 0;

  always @(negedge clk) begin
    exp_t e;
    logic busy;
    if (reset_n && chk_en) begin
      busy = (exp_q.size() > 0);
      e = busy ? exp_q.pop_front() : '0;
      chk("cycle_outputs",
          32'({load_a, load_b, swap, store, data_in, alu_func, res_valid, cmd_ready}),
          32'({e.strb, e.din, e.func, e.rv, ~busy}));
      if (e.rv) chk("held_result", 32'({res_a, res_b}), 32'({e.ra, e.rb}));
    end
  end

  task automatic accept(input cmd_kind_t kind, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [2:0] func, input int stall);
    exp_t e;
    cmd_kind  = kind;
    cmd_opa   = opa;
    cmd_opb   = opb;
    cmd_func  = func;
    cmd_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1;
    cmd_valid = 1'b0;
    res_ready = (stall == 0);
    e = '0;
    e.func = func;
    if (kind == COMPUTE) begin e.strb = 4'b1000; e.din = opa; exp_q.push_back(e); end
    if (kind == COMPUTE || kind == ACCUM) begin
      e.strb = 4'b0100; e.din = opb;  exp_q.push_back(e);
      e.strb = 4'b0001; e.din = 8'h0; exp_q.push_back(e);
    end
    if (kind == SWAP) begin e.strb = 4'b0010; exp_q.push_back(e); end
    e.strb = 4'b0000; e.din = 8'h0;
    exp_q.push_back(e);
    case (kind)
      COMPUTE: begin m_a = opa; m_b = opb; m_a = alu_fn(func, m_a, m_b); end
      ACCUM:   begin m_b = opb; m_a = alu_fn(func, m_a, m_b); end
      SWAP:    begin m_b = m_a ^ m_b; m_a = m_a ^ m_b; m_b = m_a ^ m_b; end
      default: ;
    endcase
    e.rv = 1'b1; e.ra = m_a; e.rb = m_b;
    repeat (stall + 1) exp_q.push_back(e);
  endtask

  task automatic finish_resp(input int stall, output int lat, output logic [7:0] ra, output logic [7:0] rb);
    lat = 0; ra = 8'h00; rb = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid) begin lat = k; break; end
    end
    if (lat == 0) begin
      chk("res_valid_timeout", 32'(0), 32'(1));
      exp_q.delete();
      res_ready = 1'b1;
      return;
    end
    ra = res_a; rb = res_b;
    if (stall > 0) begin
      cmd_kind  = SWAP;
      cmd_opa   = 8'hAA;
      cmd_opb   = 8'hBB;
      cmd_valid = 1'b1;
      repeat (stall) @(posedge clk);
      #1;
      res_ready = 1'b1;
      cmd_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input cmd_kind_t kind, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [2:0] func, input int stall,
                        output int lat, output logic [7:0] ra, output logic [7:0] rb);
    accept(kind, opa, opb, func, stall);
    finish_resp(stall, lat, ra, rb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] ra, rb;
    time t0;
    reset_n = 1'b1; res_ready = 1'b1; cmd_valid = 1'b0;
    cmd_kind = 2'd0; cmd_opa = 8'h00; cmd_opb = 8'h00; cmd_func = 3'd0;
    #1 reset_n = 1'b0;
    #3;
    chk("reset_outputs",
        {load_a, load_b, swap, store, data_in, alu_func, res_valid, res_a, res_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("ready_after_reset", 32'(cmd_ready), 32'(1));
    chk_en = 1'b1;

    do_cmd(COMPUTE, 8'h12, 8'h34, 3'd0, 0, lat, ra, rb);
    t0 = t_acc;
    chk("compute_lat", 32'(lat), 32'd5);
    chk("compute_res", 32'({ra, rb}), 32'h4634);
    chk("model_compute", 32'({m_a, m_b}), 32'h4634);

    do_cmd(COMPUTE, 8'hF0, 8'h20, 3'd0, 0, lat, ra, rb);
    chk("b2b_spacing_ns", 32'(t_acc - t0), 32'd60);
    chk("wrap_add_res", 32'({ra, rb}), 32'h1020);

    do_cmd(ACCUM, 8'h00, 8'h05, 3'd1, 0, lat, ra, rb);
    chk("accum_lat", 32'(lat), 32'd4);
    chk("accum_res", 32'({ra, rb}), 32'h0B05);
    chk("model_accum", 32'(m_a), 32'h0B);

    accept(COMPUTE, 8'h12, 8'h34, 3'd0, 0);
    cmd_opb = 8'h99;
    finish_resp(0, lat, ra, rb);
    chk("opb_change_res", 32'({ra, rb}), 32'h4634);

    do_cmd(SWAP, 8'h00, 8'h00, 3'd0, 0, lat, ra, rb);
    chk("swap_lat", 32'(lat), 32'd3);
    chk("swap_res", 32'({ra, rb}), 32'h3446);

    do_cmd(READ, 8'h00, 8'h00, 3'd0, 0, lat, ra, rb);
    chk("read_lat", 32'(lat), 32'd2);
    chk("read_res", 32'({ra, rb}), 32'h3446);

    do_cmd(COMPUTE, 8'h01, 8'h02, 3'd0, 7, lat, ra, rb);
    chk("stall_lat", 32'(lat), 32'd5);
    chk("stall_res", 32'({ra, rb}), 32'h0302);

    // Reset in the middle of the LDB cycle.
    accept(COMPUTE, 8'h55, 8'h66, 3'd1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ldb_before_reset", 32'(load_b), 32'(1));
    #2 reset_n = 1'b0;
    exp_q.delete();
    m_a = 8'h00; m_b = 8'h00;
    #1;
    chk("ldb_drop_on_reset", 32'(load_b), 32'(0));
    chk("mid_reset_outputs",
        {load_a, load_b, swap, store, data_in, alu_func, res_valid, res_a, res_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("ready_after_mid_reset", 32'(cmd_ready), 32'(1));
    chk("regfile_cleared", 32'({reg_a, reg_b}), 32'h0);

    do_cmd(READ, 8'h77, 8'h88, 3'd0, 0, lat, ra, rb);
    chk("read_after_reset", 32'({ra, rb}), 32'h0000);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
